// File: rtl/uart_command_receiver_if.sv
// uart_command_receiver_if: received-byte and decoded-command bundle.
// The receiver drives it as master; the game controller listens as slave.
interface uart_command_receiver_if;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       framing_error;
    logic       start_game;
    logic       difficulty_valid;
    logic       difficulty;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       number_valid;
    logic [3:0] number;
    logic       cmd_error;

    modport master (
        output rx_byte, rx_byte_valid, framing_error,
        output start_game, difficulty_valid, difficulty,
        output move_valid, move_dir, number_valid, number,
        output cmd_error
    );

    modport slave (
        input rx_byte, rx_byte_valid, framing_error,
        input start_game, difficulty_valid, difficulty,
        input move_valid, move_dir, number_valid, number,
        input cmd_error
    );
endinterface

// File: rtl/uart_command_receiver.sv
// uart_command_receiver: 8N1 16x-oversampled UART receiver plus framed command parser.
// Define CMD_STATE_FILTER_EN to gate accepted commands by current_state.
module uart_command_receiver #(
    parameter int unsigned CLOCK_FREQ     = 50000000,
    parameter int unsigned BAUD_RATE      = 115200,
    parameter int unsigned OVERSAMPLE     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx,
    input  logic [2:0]             current_state,
    uart_command_receiver_if.master bus
);
    localparam int unsigned DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_WAIT_SYNC, P_GET_CMD, P_GET_ARG, P_GET_CHK} p_state_t;

    logic          rx_s1, rx_s2, rx_s3;
    logic          fall;
    logic [DW-1:0] div_cnt;
    logic          tick;
    rx_state_t     rs, rs_n;
    logic [OW-1:0] tcnt;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic          mid_start, mid_bit;
    logic [7:0]    byte_q;
    logic          byte_valid, ferr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            {rx_s1, rx_s2, rx_s3} <= 3'b111;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign fall = rx_s3 & ~rx_s2;
    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    assign mid_start = tick && (tcnt == OW'(OVERSAMPLE / 2 - 1));
    assign mid_bit   = tick && (tcnt == OW'(OVERSAMPLE - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rs <= R_IDLE;
        else        rs <= rs_n;
    end

    always_comb begin
        rs_n = rs;
        unique case (rs)
            R_IDLE:  if (fall) rs_n = R_START;
            R_START: if (mid_start) rs_n = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (mid_bit && bcnt == 3'd7) rs_n = R_STOP;
            R_STOP:  if (mid_bit) rs_n = R_IDLE;
            default: rs_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tcnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            byte_q     <= '0;
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
            if (rs == R_IDLE) begin
                tcnt <= '0;
                bcnt <= '0;
            end else if (tick) begin
                if ((rs == R_START && mid_start) || mid_bit) tcnt <= '0;
                else                                         tcnt <= tcnt + 1'b1;
            end
            if (rs == R_DATA && mid_bit) begin
                shreg <= {rx_s2, shreg[7:1]};
                bcnt  <= bcnt + 1'b1;
            end
            if (rs == R_STOP && mid_bit) begin
                if (rx_s2) begin
                    byte_q     <= shreg;
                    byte_valid <= 1'b1;
                end else begin
                    ferr <= 1'b1;
                end
            end
        end
    end

    p_state_t      ps, ps_n;
    logic [7:0]    cmd, arg;
    logic [TW-1:0] to_cnt;
    logic          timeout, frame_done, chk_ok;
    logic          is_start, is_diff, is_move, is_num;
    logic          a_start, a_diff, a_move, a_num;
    logic          go_start, go_diff, go_move, go_num;

    assign timeout    = (to_cnt == TW'(TIMEOUT_CYCLES));
    assign frame_done = byte_valid && (ps == P_GET_CHK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ps <= P_WAIT_SYNC;
        else        ps <= ps_n;
    end

    always_comb begin
        ps_n = ps;
        if (byte_valid) begin
            unique case (ps)
                P_WAIT_SYNC: if (byte_q == SYNC_BYTE) ps_n = P_GET_CMD;
                P_GET_CMD:   ps_n = P_GET_ARG;
                P_GET_ARG:   ps_n = P_GET_CHK;
                P_GET_CHK:   ps_n = P_WAIT_SYNC;
                default:     ps_n = P_WAIT_SYNC;
            endcase
        end else if (timeout) begin
            ps_n = P_WAIT_SYNC;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
            cmd    <= '0;
            arg    <= '0;
        end else begin
            if (ps == P_WAIT_SYNC || byte_valid) to_cnt <= '0;
            else if (!timeout)                   to_cnt <= to_cnt + 1'b1;
            if (byte_valid && ps == P_GET_CMD) cmd <= byte_q;
            if (byte_valid && ps == P_GET_ARG) arg <= byte_q;
        end
    end

    always_comb begin
        chk_ok   = (byte_q == (cmd ^ arg));
        is_start = (cmd == 8'h01);
        is_diff  = (cmd == 8'h02) && (arg <= 8'd1);
        is_move  = (cmd == 8'h03) && (arg <= 8'd3);
        is_num   = (cmd == 8'h04) && (arg >= 8'd1) && (arg <= 8'd9);
    end

`ifdef CMD_STATE_FILTER_EN
    always_comb begin
        a_start = 1'b0;
        a_diff  = 1'b0;
        a_move  = 1'b0;
        a_num   = 1'b0;
        unique case (current_state)
            3'b000:         a_start = 1'b1;
            3'b001:         a_diff  = 1'b1;
            3'b011, 3'b100: begin
                a_move = 1'b1;
                a_num  = 1'b1;
            end
            default:        a_start = 1'b0;
        endcase
    end
`else
    logic unused_state;
    assign unused_state = ^current_state;
    assign a_start = 1'b1;
    assign a_diff  = 1'b1;
    assign a_move  = 1'b1;
    assign a_num   = 1'b1;
`endif

    assign go_start = chk_ok && is_start && a_start;
    assign go_diff  = chk_ok && is_diff  && a_diff;
    assign go_move  = chk_ok && is_move  && a_move;
    assign go_num   = chk_ok && is_num   && a_num;

    logic       start_q, diff_v_q, diff_q, move_v_q, num_v_q, err_q;
    logic [1:0] dir_q;
    logic [3:0] num_q;

    // Pulses land one clock after the checksum byte; arguments persist.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_q  <= 1'b0;
            diff_v_q <= 1'b0;
            diff_q   <= 1'b0;
            move_v_q <= 1'b0;
            dir_q    <= '0;
            num_v_q  <= 1'b0;
            num_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            start_q  <= frame_done && go_start;
            diff_v_q <= frame_done && go_diff;
            move_v_q <= frame_done && go_move;
            num_v_q  <= frame_done && go_num;
            err_q    <= frame_done && !(go_start || go_diff || go_move || go_num);
            if (frame_done && go_diff) diff_q <= arg[0];
            if (frame_done && go_move) dir_q  <= arg[1:0];
            if (frame_done && go_num)  num_q  <= arg[3:0];
        end
    end

    assign bus.rx_byte          = byte_q;
    assign bus.rx_byte_valid    = byte_valid;
    assign bus.framing_error    = ferr;
    assign bus.start_game       = start_q;
    assign bus.difficulty_valid = diff_v_q;
    assign bus.difficulty       = diff_q;
    assign bus.move_valid       = move_v_q;
    assign bus.move_dir         = dir_q;
    assign bus.number_valid     = num_v_q;
    assign bus.number           = num_q;
    assign bus.cmd_error        = err_q;
endmodule

// File: tb/tb_uart_command_receiver.sv
// tb_uart_command_receiver: serial-level stimulus against a frame-rule reference model.
// Runs with a fast baud divider and a short timeout to keep the cycle count small.
module tb_uart_command_receiver;
    localparam int unsigned CF  = 3686400;
    localparam int unsigned BR  = 115200;
    localparam int unsigned OS  = 16;
    localparam int unsigned TO  = 3000;
    localparam int          BIT = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [2:0] current_state = 3'b000;

    uart_command_receiver_if ifc();

    uart_command_receiver #(
        .CLOCK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS),
        .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)
    ) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .current_state(current_state), .bus(ifc)
    );

    always #5 clock = ~clock;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    longint start_cyc = 0;
    int     rxq[$];
    longint rxcyc[$];
    int     ev_kind[$];
    int     ev_val[$];
    longint ev_cyc[$];
    int     fe_cnt = 0;
    int     overlap_cnt = 0;
    int     m_diff = 0, m_dir = 0, m_num = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (ifc.rx_byte_valid) begin
            rxq.push_back(int'(ifc.rx_byte));
            rxcyc.push_back(cyc);
        end
        if (ifc.framing_error) fe_cnt++;
        if ($countones({ifc.start_game, ifc.difficulty_valid, ifc.move_valid,
                        ifc.number_valid, ifc.cmd_error}) > 1) overlap_cnt++;
        if (ifc.start_game) begin
            ev_kind.push_back(1); ev_val.push_back(0); ev_cyc.push_back(cyc);
        end
        if (ifc.difficulty_valid) begin
            ev_kind.push_back(2); ev_val.push_back(int'(ifc.difficulty)); ev_cyc.push_back(cyc);
        end
        if (ifc.move_valid) begin
            ev_kind.push_back(3); ev_val.push_back(int'(ifc.move_dir)); ev_cyc.push_back(cyc);
        end
        if (ifc.number_valid) begin
            ev_kind.push_back(4); ev_val.push_back(int'(ifc.number)); ev_cyc.push_back(cyc);
        end
        if (ifc.cmd_error) begin
            ev_kind.push_back(5); ev_val.push_back(0); ev_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        rxq.delete(); rxcyc.delete();
        ev_kind.delete(); ev_val.delete(); ev_cyc.delete();
        fe_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clock);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clock);
        end
        rx = stop;
        repeat (BIT) @(negedge clock);
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clock);
    endtask

    // Frame rules: 1=start, 2=difficulty, 3=move, 4=number, 5=error.
    function automatic int exp_kind(input int c, input int a, input int k);
        if (k != (c ^ a)) return 5;
        if (c == 1) return 1;
        if (c == 2 && a <= 1) return 2;
        if (c == 3 && a <= 3) return 3;
        if (c == 4 && a >= 1 && a <= 9) return 4;
        return 5;
    endfunction

    function automatic bit state_allows(input int kind, input int st);
        if (st == 0) return kind == 1;
        if (st == 1) return kind == 2;
        if (st == 3 || st == 4) return kind == 3 || kind == 4;
        return 1'b0;
    endfunction

    task automatic run_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        int ek, ev;
        clear_obs();
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(k);
        ek = exp_kind(int'(c), int'(a), int'(k));
`ifdef CMD_STATE_FILTER_EN
        if (ek != 5 && !state_allows(ek, int'(current_state))) ek = 5;
`endif
        ev = 0;
        if (ek == 2) ev = int'(a) % 2;
        if (ek == 3) ev = int'(a) % 4;
        if (ek == 4) ev = int'(a);
        chk("frame_bytes", rxq.size(), 4);
        chk("frame_events", ev_kind.size(), 1);
        if (ev_kind.size() == 1 && rxq.size() == 4) begin
            chk("frame_chk_byte", rxq[3], int'(k));
            chk("cmd_kind", ev_kind[0], ek);
            chk("cmd_arg", ev_val[0], ev);
            chk("cmd_latency", ev_cyc[0] - rxcyc[3], 1);
        end
        if (ek == 2) m_diff = ev;
        if (ek == 3) m_dir = ev;
        if (ek == 4) m_num = ev;
        chk("hold_difficulty", ifc.difficulty, m_diff);
        chk("hold_move_dir", ifc.move_dir, m_dir);
        chk("hold_number", ifc.number, m_num);
    endtask

    initial begin
        logic [7:0] b, c, a, k;
        longint lat;

        repeat (4) @(negedge clock);
        chk("reset_rx_byte", ifc.rx_byte, 0);
        chk("reset_pulses", {ifc.rx_byte_valid, ifc.framing_error, ifc.start_game,
                             ifc.difficulty_valid, ifc.move_valid, ifc.number_valid,
                             ifc.cmd_error}, 0);
        chk("reset_args", {ifc.difficulty, ifc.move_dir, ifc.number}, 0);
        reset = 1'b1;
        repeat (BIT) @(negedge clock);

        clear_obs();
        send_byte(8'h5A);
        lat = rxcyc.size() > 0 ? rxcyc[0] - start_cyc : 0;
        chk("byte5a_count", rxq.size(), 1);
        if (rxq.size() == 1) chk("byte5a_value", rxq[0], 'h5A);
        chk("byte5a_latency_window", (lat >= 9 * BIT) && (lat <= 10 * BIT), 1);
        chk("byte5a_no_cmd", ev_kind.size(), 0);

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5B;
            clear_obs();
            send_byte(b);
            chk("rand_byte_count", rxq.size(), 1);
            if (rxq.size() == 1) chk("rand_byte_value", rxq[0], int'(b));
            chk("rand_byte_no_cmd", ev_kind.size(), 0);
        end

        current_state = 3'b011;
        run_frame(8'h03, 8'h02, 8'h01);
        run_frame(8'h04, 8'h05, 8'h00);
        run_frame(8'h04, 8'h0A, 8'h0E);
        run_frame(8'h03, 8'h03, 8'h00);
        run_frame(8'h03, 8'h04, 8'h07);
        run_frame(8'h04, 8'h00, 8'h04);
        run_frame(8'h04, 8'h09, 8'h0D);
        run_frame(8'h04, 8'h01, 8'h05);
        current_state = 3'b001;
        run_frame(8'h02, 8'h01, 8'h03);
        run_frame(8'h02, 8'h02, 8'h00);
        run_frame(8'h05, 8'h00, 8'h05);
        current_state = 3'b000;
        run_frame(8'h01, 8'hA5, 8'hA4);

        clear_obs();
        @(negedge clock);
        rx = 1'b0;
        repeat (10) @(negedge clock);
        rx = 1'b1;
        repeat (12 * BIT) @(negedge clock);
        chk("glitch_no_byte", rxq.size(), 0);
        chk("glitch_no_ferr", fe_cnt, 0);

        clear_obs();
        send_byte(8'hA5, 1'b0);
        repeat (BIT) @(negedge clock);
        chk("ferr_pulse", fe_cnt, 1);
        chk("ferr_no_byte", rxq.size(), 0);
        current_state = 3'b011;
        send_byte(8'h04);
        send_byte(8'h07);
        send_byte(8'h03);
        chk("ferr_parser_idle_bytes", rxq.size(), 3);
        chk("ferr_parser_idle_events", ev_kind.size(), 0);

        clear_obs();
        send_byte(8'hA5);
        send_byte(8'h04);
        repeat (TO + 200) @(negedge clock);
        chk("timeout_silent", ev_kind.size(), 0);
        run_frame(8'h04, 8'h07, 8'h03);

        current_state = 3'b000;
        run_frame(8'h03, 8'h01, 8'h02);
        run_frame(8'h01, 8'h00, 8'h01);

        for (int i = 0; i < 10; i++) begin
            c = 8'($urandom_range(0, 5));
            a = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom_range(0, 11));
            k = c ^ a;
            if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
            current_state = 3'($urandom_range(0, 7));
            run_frame(c, a, k);
        end

        chk("one_hot_outputs", overlap_cnt, 0);

        @(negedge clock);
        rx = 1'b0;
        repeat (3 * BIT) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (4) @(negedge clock);
        chk("midreset_args", {ifc.difficulty, ifc.move_dir, ifc.number}, 0);
        chk("midreset_rx_byte", ifc.rx_byte, 0);
        reset = 1'b1;
        clear_obs();
        repeat (12 * BIT) @(negedge clock);
        chk("midreset_no_byte", rxq.size(), 0);
        send_byte(8'h3C);
        chk("midreset_recover_count", rxq.size(), 1);
        if (rxq.size() == 1) chk("midreset_recover_value", rxq[0], 'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
